mem_arbiter: RTL
================

# mem_arbiter

Round-robin arbiter that shares the single Avalon-MM SDRAM master port between the pixel pipeline's memory clients: z-test color writes, depth fetch reads and scanout reads. It sits between those requesters and the memory interconnect. Each requester sees its own Avalon-MM slave-style port. Outstanding read responses are routed back to the issuing requester through an in-order tag FIFO.

## Interface
Parameters:
- NREQ, 3, number of requester ports (2..8)
- AW, 26, address width
- DW, 32, data width; byteenable width is DW/8
- MAX_OUT, 8, maximum outstanding reads (power of 2, ≥2); depth of tag FIFO

Ports (clock is `clock`; reset is `reset`, synchronous and active-high):
- clock  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_address  in  NREQ*AW  requester i address at [i*AW +: AW]
- req_read  in  NREQ  read request per requester
- req_write  in  NREQ  write request per requester
- req_byteenable  in  NREQ*DW/8  byte enables per requester
- req_writedata  in  NREQ*DW  write data per requester
- req_waitrequest  out  NREQ  per-requester stall; low for exactly the accept cycle
- req_readdata  out  DW  broadcast copy of master_readdata
- req_readdatavalid  out  NREQ  one-hot, marks read data for the owning requester
- master_address  out  AW  to interconnect
- master_read  out  1  read command
- master_write  out  1  write command
- master_byteenable  out  DW/8  byte enables
- master_writedata  out  DW  write data
- master_readdata  in  DW  read data
- master_readdatavalid  in  1  read data valid, returned in issue order
- master_waitrequest  in  1  interconnect stall
- err_unexpected  out  1  sticky: readdatavalid arrived while the tag FIFO was empty

## Operation
- State machine:
  - ARB: no grant. If any eligible request exists, register a grant index and go to GRANT. Otherwise stay in ARB.
  - GRANT: master_* signals are driven combinationally from the granted requester's inputs. The transfer is accepted when (master_read|master_write) & !master_waitrequest. On accept, return to ARB. Otherwise hold the grant; it is never revoked mid-command.
- Eligible request: req_write[i], or req_read[i] with the tag FIFO not full. When the tag FIFO is full, reads are masked but writes still arbitrate.
- Round-robin order: search starts at (last_grant+1) mod NREQ and wraps. last_grant updates on accept only.
- If read and write are both asserted on one port, the write is issued and the read stays pending. Requesters must not do this; it is defined only to prevent deadlock.
- If the granted requester drops its request before accept, master_read/master_write go low. On the next cycle the state returns to ARB with no accept and last_grant unchanged.
- req_waitrequest[i] is high except in the accept cycle of requester i.
- Accepted read: push the grant index into the tag FIFO.
- master_readdatavalid: pop the head and assert req_readdatavalid[head] in the same cycle.
- A simultaneous push and pop is legal; occupancy is unchanged.
- A pop with the FIFO empty is dropped and sets err_unexpected.
- In ARB, master_read = master_write = 0. master_address, master_byteenable and master_writedata are don't-care but driven as 0.

## Timing
- Minimum 2 cycles per transfer: 1 arbitration cycle plus 1 GRANT cycle when master_waitrequest is low. Peak throughput is one command every 2 cycles.
- Request in cycle N while in ARB: command is visible on master_* in N+1 and accepted at the earliest in N+1.
- Read-data routing is combinational, zero added latency: req_readdatavalid is coincident with master_readdatavalid.
- Reset (mid-transfer included) forces:
  - state ARB, last_grant = NREQ-1, tag FIFO empty, err_unexpected = 0
  - all master_* outputs 0; req_waitrequest all 1; req_readdatavalid all 0
- Responses to reads issued before reset count as unexpected and set err_unexpected.

## Configuration
- MEM_ARB_PRIO0_EN:
  - Defined: requester 0 (scanout) wins every arbitration in which it is eligible. Requesters 1..NREQ-1 are round-robin among themselves, and last_grant tracks only those.
  - Undefined: pure round-robin over all NREQ requesters.

## Test plan
- Single write, requester 1 (addr 0x0000100, data 0xDEADBEEF, be 0xF), master_waitrequest low -> master_write high exactly 1 cycle, one cycle after the request; req_waitrequest[1] low in that cycle only.
- All 3 requesters write continuously, waitrequest low, reset state -> grant order 0,1,2,0,1,2; one accept every 2 cycles. With MEM_ARB_PRIO0_EN -> order 0,0,0…; 1 and 2 never granted while 0 requests.
- Requester 2 read with master_waitrequest held high 5 cycles -> master_address/master_read stable for all 6 cycles. Accept on the 6th; the later readdatavalid (data 0x12345678) pulses req_readdatavalid = 3'b100.
- Requester 0 issues 8 reads without responses, MAX_OUT = 8 -> 9th read not granted, while a requester 1 write is granted. One readdatavalid -> the 9th read is granted.
- Interleaved reads from requesters 0 and 1 (order 0,1,0) with responses 3 cycles later, overlapping a new push -> req_readdatavalid sequence 001, 010, 001.
- Assert reset while a read is outstanding, then deliver readdatavalid -> no req_readdatavalid bit set; err_unexpected = 1 and stays 1 until the next reset.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: per-requester Avalon-MM slave ports plus the shared SDRAM master port.
// The arbiter connects through the master modport; requesters and the interconnect model use slave.
interface mem_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 26,
  parameter int DW   = 32
);
  logic [NREQ*AW-1:0]   req_address;
  logic [NREQ-1:0]      req_read;
  logic [NREQ-1:0]      req_write;
  logic [NREQ*DW/8-1:0] req_byteenable;
  logic [NREQ*DW-1:0]   req_writedata;
  logic [NREQ-1:0]      req_waitrequest;
  logic [DW-1:0]        req_readdata;
  logic [NREQ-1:0]      req_readdatavalid;

  logic [AW-1:0]        master_address;
  logic                 master_read;
  logic                 master_write;
  logic [DW/8-1:0]      master_byteenable;
  logic [DW-1:0]        master_writedata;
  logic [DW-1:0]        master_readdata;
  logic                 master_readdatavalid;
  logic                 master_waitrequest;

  modport master (
    input  req_address, req_read, req_write, req_byteenable, req_writedata,
    output req_waitrequest, req_readdata, req_readdatavalid,
    output master_address, master_read, master_write, master_byteenable, master_writedata,
    input  master_readdata, master_readdatavalid, master_waitrequest
  );

  modport slave (
    output req_address, req_read, req_write, req_byteenable, req_writedata,
    input  req_waitrequest, req_readdata, req_readdatavalid,
    input  master_address, master_read, master_write, master_byteenable, master_writedata,
    output master_readdata, master_readdatavalid, master_waitrequest
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM master among NREQ pixel-pipeline clients.
// Optional MEM_ARB_PRIO0_EN: requester 0 (scanout) always wins; 1..NREQ-1 round-robin among themselves.
module mem_arbiter #(
  parameter int NREQ    = 3,
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int MAX_OUT = 8
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.master bus,
  output logic          err_unexpected
);
  localparam int BW = DW / 8;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = $clog2(MAX_OUT);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  typedef enum logic {ARB, GRANT} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] last_q, last_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [IW-1:0] tag_q [MAX_OUT];

  logic            fifo_full, fifo_empty;
  logic            active, cmd, accept, push, pop_req, pop;
  logic [NREQ-1:0] elig;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   head;
  int              gi;
  int              c;

  assign fifo_full  = (cnt_q == (PW+1)'(MAX_OUT));
  assign fifo_empty = (cnt_q == '0);
  // Reads are held back only while the tag FIFO cannot take another entry.
  assign elig       = bus.req_write | (bus.req_read & {NREQ{~fifo_full}});

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    c        = 0;
`ifdef MEM_ARB_PRIO0_EN
    if (elig[0]) pick_vld = 1'b1;
    for (int k = 1; k < NREQ; k++) begin
      c = 1 + ((int'(last_q) - 1 + k) % (NREQ - 1));
      if (!pick_vld && elig[c]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(c);
      end
    end
`else
    for (int k = 1; k <= NREQ; k++) begin
      c = (int'(last_q) + k) % NREQ;
      if (!pick_vld && elig[c]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(c);
      end
    end
`endif
  end

  // Master side is a straight mux of the granted port; reset forces it quiet immediately.
  assign active = (state_q == GRANT) && !reset;
  assign gi     = int'(gnt_q);

  always_comb begin
    bus.master_address    = '0;
    bus.master_read       = 1'b0;
    bus.master_write      = 1'b0;
    bus.master_byteenable = '0;
    bus.master_writedata  = '0;
    if (active) begin
      bus.master_address    = bus.req_address[gi*AW +: AW];
      bus.master_byteenable = bus.req_byteenable[gi*BW +: BW];
      bus.master_writedata  = bus.req_writedata[gi*DW +: DW];
      bus.master_write      = bus.req_write[gnt_q];
      bus.master_read       = bus.req_read[gnt_q] & ~bus.req_write[gnt_q];
    end
  end

  assign cmd     = bus.master_read | bus.master_write;
  assign accept  = cmd & ~bus.master_waitrequest;
  assign push    = accept & bus.master_read;
  assign pop_req = bus.master_readdatavalid & ~reset;
  assign pop     = pop_req & ~fifo_empty;
  assign head    = tag_q[rp_q];

  assign bus.req_readdata = bus.master_readdata;
  assign err_unexpected   = err_q;

  always_comb begin
    bus.req_waitrequest   = '1;
    bus.req_readdatavalid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (accept && gnt_q == IW'(i)) bus.req_waitrequest[i]   = 1'b0;
      if (pop && head == IW'(i))     bus.req_readdatavalid[i] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wp_d    = wp_q + PW'(push);
    rp_d    = rp_q + PW'(pop);
    cnt_d   = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    err_d   = err_q | (pop_req & fifo_empty);
    case (state_q)
      ARB: begin
        if (pick_vld) begin
          state_d = GRANT;
          gnt_d   = pick_idx;
        end
      end
      GRANT: begin
        if (accept) begin
          state_d = ARB;
`ifdef MEM_ARB_PRIO0_EN
          if (gnt_q != '0) last_d = gnt_q;
`else
          last_d = gnt_q;
`endif
        end else if (!cmd) begin
          // Requester withdrew: give up the grant without touching round-robin order.
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARB;
      gnt_q   <= '0;
      last_q  <= LAST_RST;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) tag_q[wp_q] <= gnt_q;
  end
endmodule
